// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
//
// Handshake: the requester raises start with a and b valid. The operands are
// taken on the first rising edge where start=1 and the unit is idle or in its
// DONE cycle. busy is high for the W cycles of computation, during which
// start, a and b are ignored. done is high for exactly one cycle, in which
// diff, borrow_out and overflow first show the new result. The result
// outputs then hold until the next operation completes.
interface serial_subtractor_if #(
    parameter int W = serial_subtractor_pkg::DEFAULT_W
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: a - b - b_in, producing a difference bit
// and a borrow to the next more significant bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor. It computes a - b LSB first, one
// bit per clock, through a single full-subtractor cell. Results are parallel
// and are held in output registers that change only on the DONE edge.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_subtractor_if.slave    bus,
    output state_e                state_dbg
);

    localparam int CNT_W = $clog2(W + 1);

    state_e             state;
    state_e             state_nx;
    logic [W-1:0]       a_sr;
    logic [W-1:0]       b_sr;
    logic [W-1:0]       res_sr;
    logic               borrow_ff;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       diff_q;
    logic               borrow_q;
    logic               overflow_q;

    logic               load;
    logic               step;
    logic               last;
    logic               cell_d;
    logic               cell_bout;

    // The cell always works on the current operand LSBs and the running borrow.
    full_subtractor u_cell (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .b_in  (borrow_ff),
        .diff  (cell_d),
        .b_out (cell_bout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and the per-cycle datapath controls.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(W - 1)) begin
                    last     = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start seen in the DONE cycle is accepted back-to-back.
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = ST_RUN;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand shift registers, result accumulator, borrow FF and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            borrow_ff <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            a_sr      <= bus.a;
            b_sr      <= bus.b;
            borrow_ff <= 1'b0;
            cnt       <= '0;
        end else if (step) begin
            a_sr      <= {1'b0, a_sr[W-1:1]};
            b_sr      <= {1'b0, b_sr[W-1:1]};
            res_sr    <= {cell_d, res_sr[W-1:1]};
            borrow_ff <= cell_bout;
            cnt       <= cnt + CNT_W'(1);
        end
    end

    // Result registers. On the last bit, the cell inputs are the operand sign
    // bits and cell_d is the result sign bit, so overflow needs no extra state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (last) begin
            diff_q     <= {cell_d, res_sr[W-1:1]};
            borrow_q   <= cell_bout;
            overflow_q <= (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
        end
    end

    assign bus.busy       = (state == ST_RUN);
    assign bus.done       = (state == ST_DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = overflow_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (W=8): directed cases, back-to-back operation,
// ignored start, asynchronous reset mid-operation and a random sweep checked
// against an arithmetic reference model.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = 8;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_e state_dbg;

    serial_subtractor_if #(.W(W)) bus ();

    serial_subtractor #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int unsigned cycle = 0;

    // {overflow, borrow_out, diff}
    logic [W+1:0] exp_q[$];

    // Free-running edge counter for timing measurements.
    always @(posedge clk) cycle++;

    // Watchdog.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] av, input logic [W-1:0] bv);
        int           sd;
        logic [W-1:0] d;
        logic         bor;
        logic         ovf;
        sd  = int'($signed(av)) - int'($signed(bv));
        d   = av - bv;
        bor = (av < bv);
        ovf = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        return {ovf, bor, d};
    endfunction

    // Waits for done, returning the number of edges taken (-1 on timeout).
    task automatic wait_done(input string tag, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_diff"},   32'(bus.diff),       32'(e[W-1:0]));
            check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e[W]));
            check({tag, "_ovf"},    32'(bus.overflow),   32'(e[W+1]));
        end
    endtask

    // Full single operation; called and returns on a falling edge.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        int lat;
        exp_q.push_back(ref_model(av, bv));
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom_range(0, 255));
        bus.b     = W'($urandom_range(0, 255));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(tag, lat);
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check_result(tag);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"},  32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int extra;
        int unsigned t_first;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(bus.busy),       32'd0);
        check("rst_done",   32'(bus.done),       32'd0);
        check("rst_diff",   32'(bus.diff),       32'd0);
        check("rst_borrow", 32'(bus.borrow_out), 32'd0);
        check("rst_ovf",    32'(bus.overflow),   32'd0);
        check("rst_state",  32'(state_dbg),      32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op(8'h5A, 8'h23, "d_5a_23");
        run_op(8'h00, 8'h01, "d_00_01");
        run_op(8'h80, 8'h01, "d_80_01");
        run_op(8'h7F, 8'hFF, "d_7f_ff");
        run_op(8'hFF, 8'hFF, "d_ff_ff");

        // Back-to-back with start held high.
        exp_q.push_back(ref_model(8'h10, 8'h10));
        exp_q.push_back(ref_model(8'h03, 8'h05));
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h10;
        @(posedge clk);
        #1;
        bus.a = 8'h03;
        bus.b = 8'h05;
        wait_done("b2b_first", lat);
        check("b2b_first_latency", 32'(lat), 32'(W));
        t_first = cycle;
        check_result("b2b_first");
        wait_done("b2b_second", lat);
        bus.start = 1'b0;
        check("b2b_gap", 32'(cycle - t_first), 32'(W + 1));
        check_result("b2b_second");
        @(posedge clk);
        #1;
        check("b2b_no_third", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // Start pulsed during RUN is ignored.
        exp_q.push_back(ref_model(8'h5A, 8'h23));
        bus.start = 1'b1;
        bus.a     = 8'h5A;
        bus.b     = 8'h23;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ign", lat);
        check("ign_latency", 32'(lat), 32'(W - 3));
        check_result("ign");
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        check("ign_single_done", 32'(extra), 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        run_op(8'h00, 8'h01, "pre_rst");
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy",   32'(bus.busy),       32'd0);
        check("mrst_done",   32'(bus.done),       32'd0);
        check("mrst_diff",   32'(bus.diff),       32'd0);
        check("mrst_borrow", 32'(bus.borrow_out), 32'd0);
        check("mrst_ovf",    32'(bus.overflow),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
        end
        check("post_rst_quiet", 32'(extra), 32'd0);
        check("post_rst_diff",  32'(bus.diff), 32'd0);
        @(negedge clk);

        // Random sweep.
        repeat (1000) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_op(ra, rb, "rnd");
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
